uart_tx_fifo: RTL and testbench

- Transmit side of the riscvcore debug UART. It drives the top-level UART_TX pin that the bench monitors after initFinish.
- Accepts bytes from the core's MMIO store path through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed baud derived from clk (25 MHz on the 40 ns bench clock).

---
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Debug UART transmitter: 16-entry byte FIFO behind a valid/ready port, drained
// by an 8N1 LSB-first serialiser with a registered line output.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_valid,
  input  logic [7:0]         tx_data,
  output logic               tx_ready,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               UART_TX
);

  localparam int unsigned    DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]    CNT_MAX  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [7:0]           mem_q [DEPTH];

  logic push, pop, fifo_empty, cell_done;

  // Ready is decoded from the registered level only, so a same-cycle pop on
  // a full FIFO does not open the door until the next cycle.
  assign tx_ready   = (level_q != LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign push       = tx_valid && tx_ready;
  assign cell_done  = (cnt_q == '0);

  assign tx_busy    = busy_q;
  assign fifo_level = level_q;
  assign UART_TX    = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = CNT_MAX;
          state_d = START;
        end
      end
      START: begin
        if (cell_done) begin
          cnt_d   = CNT_MAX;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cell_done) begin
          cnt_d   = CNT_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (cell_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            cnt_d   = CNT_MAX;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  // Line value follows the current state, so it lags the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= 8'hFF;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset so it maps onto distributed RAM; only written slots
  // are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-timeline reference model compared every cycle,
// a line decoder, and directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;
  localparam int C  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_valid = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_ready, tx_busy, UART_TX;
  logic [AW:0]   fifo_level;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .fifo_level(fifo_level),
    .UART_TX(UART_TX)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_e = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue plus the position inside the frame on air.
  logic [7:0] mq[$];
  logic [7:0] m_acc[$];
  logic [7:0] m_cur = 8'h00;
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic       m_line = 1'b1;
  logic       m_started = 1'b0;

  function automatic logic bitval(input int t, input logic [7:0] b);
    if (t < C)     return 1'b0;
    if (t < 9 * C) return b[(t - C) / C];
    return 1'b1;
  endfunction

  initial begin
    logic do_pop, do_push;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        m_active  = 1'b0;
        m_t       = 0;
        m_line    = 1'b1;
        m_started = 1'b1;
      end else begin
        do_pop  = (!m_active || m_t == 10 * C - 1) && mq.size() > 0;
        do_push = tx_valid && mq.size() < (1 << AW);
        m_line  = m_active ? bitval(m_t, m_cur) : 1'b1;
        if (do_pop) begin
          m_cur    = mq.pop_front();
          m_active = 1'b1;
          m_t      = 0;
        end else if (m_active) begin
          if (m_t == 10 * C - 1) m_active = 1'b0;
          else                   m_t++;
        end
        if (do_push) begin
          mq.push_back(tx_data);
          m_acc.push_back(tx_data);
        end
      end
    end
  end

  // Per-cycle compare plus line decoder (samples mid-cell).
  logic [7:0] rx_q[$];
  int         fall_cyc[$];
  int         rx_cnt = -1;
  logic       rx_prev = 1'b1;
  logic [9:0] rx_bits = '0;

  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("uart_tx",    32'(UART_TX),    32'(m_line));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("tx_busy",    32'(tx_busy),    32'(m_active || mq.size() != 0));
        chk("tx_ready",   32'(tx_ready),   32'(mq.size() != (1 << AW)));
      end
      if (rst) rx_cnt = -1;
      else if (rx_cnt < 0) begin
        if (rx_prev && !UART_TX) begin
          rx_cnt = 0;
          fall_cyc.push_back(cyc);
        end
      end else rx_cnt++;
      if (rx_cnt >= 0 && (rx_cnt % C) == C / 2) begin
        k = rx_cnt / C;
        rx_bits[k] = UART_TX;
        if (k == 9) begin
          chk("start_bit", 32'(rx_bits[0]), 32'd0);
          chk("stop_bit",  32'(rx_bits[9]), 32'd1);
          rx_q.push_back(rx_bits[8:1]);
          rx_cnt = -1;
        end
      end
      rx_prev = UART_TX;
    end
  end

  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    last_e   = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while ((tx_busy || rx_cnt >= 0) && i < budget) begin @(posedge clk); #1; i++; end
    chk(nm, 32'(i >= budget), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    fall_cyc.delete();
    m_acc.delete();
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, acc, mx, nfall;
    logic [7:0] b[5];

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("rst_uart_tx", 32'(UART_TX), 32'd1);
    chk("rst_busy",    32'(tx_busy), 32'd0);
    chk("rst_level",   32'(fifo_level), 32'd0);
    chk("rst_ready",   32'(tx_ready), 32'd1);
    repeat (2) begin @(posedge clk); #1; end

    // Single byte: latency, pattern, busy drop
    clear_rx();
    push(8'h55);
    e0 = last_e;
    begin
      int i;
      i = 0;
      while (tx_busy && i < 200) begin @(negedge clk); i++; end
      chk("busy_fall_cycle", 32'(cyc), 32'(e0 + 41));
    end
    wait_idle(200, "single_timeout");
    chk("single_nframes", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("single_byte", 32'(rx_q[0]), 32'h55);
    if (fall_cyc.size() > 0) chk("single_fall", 32'(fall_cyc[0]), 32'(e0 + 2));

    // Back-to-back
    clear_rx();
    push(8'hA5);
    e0 = last_e;
    push(8'h3C);
    wait_cyc(e0 + 10);
    chk("b2b_level_mid", 32'(fifo_level), 32'd1);
    wait_idle(300, "b2b_timeout");
    chk("b2b_nframes", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("b2b_byte0", 32'(rx_q[0]), 32'hA5);
      chk("b2b_byte1", 32'(rx_q[1]), 32'h3C);
    end
    if (fall_cyc.size() == 2) chk("b2b_spacing", 32'(fall_cyc[1] - fall_cyc[0]), 32'(10 * C));

    // Full FIFO
    clear_rx();
    acc = 0;
    mx  = 0;
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(i);
      if (tx_ready) acc++;
      @(posedge clk); #1;
      if (int'(fifo_level) > mx) mx = int'(fifo_level);
    end
    tx_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd17);
    chk("full_peak",     32'(mx),  32'd16);
    wait_idle(2000, "full_timeout");
    chk("full_nframes", 32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17)
      for (int i = 0; i < 17; i++) chk("full_order", 32'(rx_q[i]), 32'(i));

    // Push coinciding with the STOP->START pop at level 3
    clear_rx();
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    push(b[0]);
    e0 = last_e;
    for (int i = 1; i < 4; i++) push(b[i]);
    wait_cyc(e0 + 40);
    chk("pp_level_before", 32'(fifo_level), 32'd3);
    push(b[4]);
    chk("pp_edge", 32'(last_e), 32'(e0 + 41));
    chk("pp_level_after", 32'(fifo_level), 32'd3);
    wait_idle(400, "pp_timeout");
    chk("pp_nframes", 32'(rx_q.size()), 32'd5);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("pp_order", 32'(rx_q[i]), 32'(b[i]));

    // Reset during data bit 3 of 0xF0 with two bytes queued
    clear_rx();
    push(8'hF0);
    e0 = last_e;
    push(8'h12);
    push(8'h34);
    wait_cyc(e0 + 18);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_uart_tx", 32'(UART_TX), 32'd1);
    chk("mrst_level",   32'(fifo_level), 32'd0);
    chk("mrst_busy",    32'(tx_busy), 32'd0);
    nfall = fall_cyc.size();
    repeat (100) begin @(posedge clk); #1; end
    chk("mrst_no_frames", 32'(fall_cyc.size()), 32'(nfall));
    chk("mrst_no_bytes",  32'(rx_q.size()), 32'd0);
    push(8'h81);
    wait_idle(200, "mrst_timeout");
    chk("mrst_new_nframes", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) chk("mrst_new_byte", 32'(rx_q[0]), 32'h81);

    // Randomised traffic: sparse, then dense enough to fill the FIFO
    clear_rx();
    for (int i = 0; i < 1200; i++) begin
      tx_valid = (i < 800) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 1) == 0);
      tx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    wait_idle(3000, "rand_timeout");
    chk("rand_nframes", 32'(rx_q.size()), 32'(m_acc.size()));
    if (rx_q.size() == m_acc.size())
      for (int i = 0; i < rx_q.size(); i++) chk("rand_byte", 32'(rx_q[i]), 32'(m_acc[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
